// File: rtl/hamming_decoder_pipe.sv
// hamming_decoder_pipe: two-stage Hamming(7,4) decoder/corrector with valid/ready on both sides.
// Define HAMMING_DEC_CNT_EN to build the saturating corrected-word counter; otherwise corr_cnt is 0.
module hamming_decoder_pipe #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       data_o,
    output logic [2:0]       syndrome_o,
    output logic             corrected_o,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] corr_cnt
);

    // Handshake: a word moves on a rising edge where valid && ready; valid never depends on ready,
    // and a held output word (out_valid && !out_ready) keeps data_o/status stable until taken.
    logic       adv;
    logic       s1_valid;
    logic [3:0] s1_data;
    logic [2:0] s1_syn;
    logic [2:0] in_syn;
    logic [3:0] fixed_data;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && enable;

    assign in_syn = {data_in[3] ^ data_in[4] ^ data_in[5] ^ data_in[6],
                     data_in[1] ^ data_in[2] ^ data_in[5] ^ data_in[6],
                     data_in[0] ^ data_in[2] ^ data_in[4] ^ data_in[6]};

    // Data bits live at codeword positions 3,5,6,7; flipping parity positions leaves data untouched.
    always_comb begin
        fixed_data    = s1_data;
        fixed_data[0] = s1_data[0] ^ (s1_syn == 3'd3);
        fixed_data[1] = s1_data[1] ^ (s1_syn == 3'd5);
        fixed_data[2] = s1_data[2] ^ (s1_syn == 3'd6);
        fixed_data[3] = s1_data[3] ^ (s1_syn == 3'd7);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_data     <= 4'd0;
            s1_syn      <= 3'd0;
            out_valid   <= 1'b0;
            data_o      <= 4'd0;
            syndrome_o  <= 3'd0;
            corrected_o <= 1'b0;
        end else if (adv) begin
            s1_valid    <= in_valid && in_ready;
            s1_data     <= {data_in[6], data_in[5], data_in[4], data_in[2]};
            s1_syn      <= in_syn;
            out_valid   <= s1_valid;
            data_o      <= fixed_data;
            syndrome_o  <= s1_syn;
            corrected_o <= (s1_syn != 3'd0);
        end
    end

`ifdef HAMMING_DEC_CNT_EN
    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt <= '0;
        end else if (clr_cnt) begin
            corr_cnt <= '0;
        end else if (out_valid && out_ready && corrected_o && (corr_cnt != {CNT_W{1'b1}})) begin
            corr_cnt <= corr_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_clr;
    assign unused_clr = clr_cnt;
    assign corr_cnt   = '0;
`endif

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// tb_hamming_decoder_pipe: vector table, directed corner sequences and random traffic checked
// against a nearest-codeword reference decoder and a scoreboard queue.
module tb_hamming_decoder_pipe;

    localparam int CNT_W = 8;
`ifdef HAMMING_DEC_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enable = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [6:0]       data_in = 7'd0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [3:0]       data_o;
    logic [2:0]       syndrome_o;
    logic             corrected_o;
    logic             clr_cnt = 1'b0;
    logic [CNT_W-1:0] corr_cnt;

    hamming_decoder_pipe #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_o     (data_o),
        .syndrome_o (syndrome_o),
        .corrected_o(corrected_o),
        .clr_cnt    (clr_cnt),
        .corr_cnt   (corr_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- counters and check helper ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] c;
        c[2] = d[0];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[3] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

    // Hamming(7,4) is perfect: every word is within distance 1 of exactly one codeword.
    function automatic logic [7:0] ref_decode(input logic [6:0] code);
        logic [7:0] r;
        logic [6:0] diff;
        r = 8'd0;
        for (int d = 0; d < 16; d++) begin
            diff = encode(4'(d)) ^ code;
            if ($countones(diff) <= 1) begin
                r[7:4] = 4'(d);
                for (int b = 0; b < 7; b++)
                    if (diff[b]) r[3:1] = 3'(b + 1);
                r[0] = (diff != 7'd0);
            end
        end
        return r;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [7:0]       exp_q[$];
    logic [CNT_W-1:0] cnt_model = '0;
    int cyc = 0;
    int out_cnt = 0;
    int first_cyc = 0;
    int last_cyc = 0;

    always @(negedge clk) begin
        logic [7:0] e;
        cyc++;
        if (rst) begin
            exp_q.delete();
            cnt_model = '0;
        end else begin
            chk("corr_cnt_track", corr_cnt, cnt_model);
            if (out_valid && out_ready) begin
                chk("out_has_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("data_o", data_o, e[7:4]);
                    chk("syndrome_o", syndrome_o, e[3:1]);
                    chk("corrected_o", corrected_o, e[0]);
                    if (out_cnt == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    out_cnt++;
                    if (CNT_ON && e[0] && cnt_model != {CNT_W{1'b1}}) cnt_model = cnt_model + 1'b1;
                end
            end
            if (CNT_ON && clr_cnt) cnt_model = '0;
            if (in_valid && in_ready) exp_q.push_back(ref_decode(data_in));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        logic [6:0] code;
        logic [3:0] data;
        logic [2:0] syn;
        logic       corr;
    } vec_t;

    vec_t vecs[8];

    // Single word from an empty pipe: nothing after one edge, result after two.
    task automatic run_vec(input vec_t v, input string tag);
        in_valid = 1'b1;
        data_in  = v.code;
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_lat1_idle"}, out_valid, 0);
        tick();
        @(negedge clk);
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_data"}, data_o, v.data);
        chk({tag, "_syn"}, syndrome_o, v.syn);
        chk({tag, "_corr"}, corrected_o, v.corr);
        tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [3:0] d;
        logic [6:0] w;
        bit got;

        vecs[0] = '{7'h55, 4'hB, 3'd0, 1'b0};
        vecs[1] = '{7'h51, 4'hB, 3'd3, 1'b1};
        vecs[2] = '{7'h00, 4'h0, 3'd0, 1'b0};
        vecs[3] = '{7'h7F, 4'hF, 3'd0, 1'b0};
        vecs[4] = '{7'h01, 4'h0, 3'd1, 1'b1};
        vecs[5] = '{7'h40, 4'h0, 3'd7, 1'b1};
        vecs[6] = '{7'h7E, 4'hF, 3'd1, 1'b1};
        vecs[7] = '{7'h15, 4'hB, 3'd7, 1'b1};

        // reset
        #2 rst = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_syndrome", syndrome_o, 0);
        chk("rst_corrected", corrected_o, 0);
        chk("rst_corr_cnt", corr_cnt, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // vector table
        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
        drain(2);

        // sweep: every data value with each single-bit flip plus no flip, back to back
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        out_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            for (int f = 0; f < 8; f++) begin
                w = encode(4'(i));
                if (f < 7) w[f] = ~w[f];
                in_valid = 1'b1;
                data_in  = w;
                tick();
            end
        end
        drain(4);
        chk("sweep_count", out_cnt, 128);
        chk("sweep_span", last_cyc - first_cyc, 127);
        chk("sweep_corr_cnt", corr_cnt, CNT_ON ? 112 : 0);
        chk("sweep_queue_empty", exp_q.size(), 0);

        // backpressure: 00, 7F, 55 with a 3-cycle consumer stall after the first output
        out_cnt  = 0;
        in_valid = 1'b1;
        data_in  = 7'h00;
        tick();
        data_in  = 7'h7F;
        tick();
        out_ready = 1'b0;
        data_in   = 7'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_data_hold", data_o, 4'h0);
            tick();
        end
        out_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            tick();
        end
        chk("bp_accept_55", got, 1);
        drain(5);
        chk("bp_out_count", out_cnt, 3);
        chk("bp_queue_empty", exp_q.size(), 0);

        // enable low: no accepts, no output
        enable   = 1'b0;
        in_valid = 1'b1;
        data_in  = 7'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("en_in_ready", in_ready, 0);
            chk("en_out_valid", out_valid, 0);
            tick();
        end
        in_valid = 1'b0;
        enable   = 1'b1;
        tick();

        // reset with two words in flight
        in_valid = 1'b1;
        data_in  = 7'h51;
        tick();
        data_in  = 7'h01;
        tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_corr_cnt", corr_cnt, 0);
        chk("rst_mid_data_o", data_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_vec(vecs[1], "post_rst");
        drain(2);

        // saturation: 300 corrupted words
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        for (int i = 0; i < 300; i++) begin
            d = 4'($urandom_range(0, 15));
            w = encode(d);
            w[$urandom_range(0, 6)] ^= 1'b1;
            in_valid = 1'b1;
            data_in  = w;
            tick();
        end
        drain(4);
        chk("sat_corr_cnt", corr_cnt, CNT_ON ? 255 : 0);

        // clear coinciding with a corrected handshake
        in_valid = 1'b1;
        data_in  = encode(4'd5) ^ 7'h01;
        tick();
        in_valid = 1'b0;
        tick();
        clr_cnt = 1'b1;
        @(negedge clk);
        chk("clr_hs_valid", out_valid && corrected_o, 1);
        tick();
        clr_cnt = 1'b0;
        chk("clr_hs_corr_cnt", corr_cnt, 0);
        drain(3);

        // random traffic including double errors, stalls, enable gaps and clears
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            data_in   = 7'($urandom_range(0, 127));
            out_ready = ($urandom_range(0, 3) != 0);
            enable    = ($urandom_range(0, 4) != 0);
            clr_cnt   = ($urandom_range(0, 49) == 0);
            tick();
        end
        out_ready = 1'b1;
        enable    = 1'b1;
        clr_cnt   = 1'b0;
        drain(6);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
